nonce_search_ctrl: RTL and testbench
====================================

Name: nonce_search_ctrl

Overview:
- Controller that sequences one sha256_module instance through a nonce search, the inner loop of the mining flow.
- Takes a 512-bit block template, inserts each candidate nonce, and runs the core once per nonce.
- After each run, compares the 256-bit hash against a target.
- Stops on the first hit, on range exhaustion, on abort, or on a core timeout. Sits between the Avalon register front-end and the SHA256 core.

Parameters:
NONCE_WORD, 3, 32-bit word index in the block where the nonce is inserted (bits [32*NONCE_WORD+31 : 32*NONCE_WORD]); legal range 0-15
CORE_TIMEOUT, 1024, max cycles in WAIT before the core is declared hung; legal range 2 to 2^16-1

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high; resets all state
cfg_block  in  512  block template; sampled on accepted go
cfg_target  in  256  hit when core_hash < cfg_target (unsigned); sampled on go
cfg_nonce_start  in  32  first nonce; sampled on go
cfg_nonce_end  in  32  last nonce, inclusive; sampled on go
go  in  1  single-cycle start pulse
abort  in  1  single-cycle cancel pulse
busy  out  1  high from the cycle after an accepted go until return to IDLE
found  out  1  sticky; hit found
exhausted  out  1  sticky; range finished without a hit
timeout  out  1  sticky; core_done not seen within CORE_TIMEOUT
result_nonce  out  32  last nonce tried (the hit nonce if found)
result_hash  out  256  hash of result_nonce
attempts  out  32  number of completed hashes in the current run
core_reset  out  1  reset to the core; equals reset OR the internal pulse
core_start  out  1  single-cycle start to the core
core_block  out  512  latched template with the current nonce inserted; registered
core_hash  in  256  core result
core_done  in  1  core result valid; may stay high until the core is reset

Behaviour:
- Reset values:
  - All outputs 0. core_reset = 1 while reset is high.
  - FSM in IDLE.
- FSM states: IDLE, CRST, START, WAIT, CHECK.
- IDLE:
  - go accepted: latch the config, nonce <= cfg_nonce_start, attempts <= 0.
  - Clear found/exhausted/timeout, go to CRST.
  - If go and abort arrive in the same cycle, abort wins and go is ignored.
- CRST:
  - Internal core_reset high for exactly 1 cycle.
  - core_block updated with the current nonce. Go to START.
- START: core_start high for 1 cycle; wait counter <= 0; go to WAIT.
- WAIT:
  - Count cycles. On core_done: capture core_hash into result_hash, go to CHECK.
  - When the wait counter reaches CORE_TIMEOUT without done: timeout <= 1, pulse the core reset, go to IDLE.
- CHECK (1 cycle):
  - result_nonce <= nonce; attempts++ (saturates at 2^32-1).
  - result_hash < target: found <= 1, go to IDLE.
  - Else if nonce == nonce_end: exhausted <= 1, go to IDLE.
  - Else nonce <= nonce+1 modulo 2^32, go to CRST.
- Nonce range:
  - The range wraps: start > end sweeps through 0xFFFFFFFF to 0.
  - start == end runs exactly one attempt.
- Hit comparison: strict. A hash equal to the target is not a hit.
- Per-attempt latency: 1 (CRST) + 1 (START) + D + 1 (CHECK), where D = cycles from core_start to core_done.
- The core is re-reset before every attempt, so a stale high core_done is never sampled in WAIT.
- abort:
  - In any non-IDLE state: core reset pulsed 1 cycle, go to IDLE next cycle, status flags unchanged (all 0).
  - abort takes priority over core_done and over the timeout in the same cycle.
- go while busy: ignored; the latched config is unchanged.
- cfg_* changes while busy have no effect.
- Reset mid-run: FSM returns to IDLE on the next edge, all flags cleared, core held in reset.
- Results persist in IDLE until the next accepted go.

Decomposition:
- Package nonce_search_pkg holds:
  - the state enum (state_t)
  - NONCE_W=32, BLOCK_W=512, HASH_W=256 constants
  - an insert_nonce function (template, nonce, word index → block)
- Sub-module hash_lt_cmp: 256-bit unsigned less-than, purely combinational.
  - Isolated so it can later be pipelined; if pipelined, CHECK gains one cycle per stage.

Test Plan:
- Core model with D=4 and hash=nonce zero-extended; target=5, start=2, end=9 → found=1, result_nonce=2, attempts=1, 7 cycles from go to IDLE.
- Same model, target=0, start=0xFFFFFFFE, end=1 → attempts=4, nonces tried FFFFFFFE, FFFFFFFF, 0, 1; exhausted=1, found=0.
- Target=7 with hash equal to 7 at nonce 7 and start=end=7 → found=0, exhausted=1, attempts=1.
- Core model that never asserts done, CORE_TIMEOUT=16 → timeout=1 exactly 16 cycles after core_start; core_reset pulses; busy falls.
- abort during WAIT on the same cycle as core_done → IDLE next cycle, no flags set, attempts unchanged. A go pulse while busy → no restart, config unchanged.
- Check core_block word NONCE_WORD=3 equals the nonce and all other words equal the template each attempt. reset asserted mid-WAIT → all outputs 0 next cycle.

Source files
------------

// File: rtl/nonce_search_pkg.sv
`default_nettype none
// ============================================================================
// Module   : nonce_search_pkg
// Brief    : Shared widths, FSM state encoding and nonce-insertion helper for
//            the nonce search controller.
// Revision : 1.0 - initial release
// ============================================================================
package nonce_search_pkg;

    localparam int NONCE_W = 32;
    localparam int BLOCK_W = 512;
    localparam int HASH_W  = 256;

    typedef logic [2:0] state_t;

    localparam state_t S_IDLE  = 3'd0;
    localparam state_t S_CRST  = 3'd1;
    localparam state_t S_START = 3'd2;
    localparam state_t S_WAIT  = 3'd3;
    localparam state_t S_CHECK = 3'd4;

    // Replace 32-bit word 'word' of the template with the nonce.
    function automatic logic [BLOCK_W-1:0] insert_nonce(
        input logic [BLOCK_W-1:0] tmpl,
        input logic [NONCE_W-1:0] nonce,
        input logic [3:0]         word
    );
        logic [BLOCK_W-1:0] mask;
        logic [BLOCK_W-1:0] ins;
        mask = {{(BLOCK_W-NONCE_W){1'b0}}, {NONCE_W{1'b1}}} << {word, 5'd0};
        ins  = {{(BLOCK_W-NONCE_W){1'b0}}, nonce} << {word, 5'd0};
        return (tmpl & ~mask) | ins;
    endfunction

endpackage
`default_nettype wire

// File: rtl/nonce_search_ctrl_hash_lt_cmp.sv
`default_nettype none
// ============================================================================
// Module   : hash_lt_cmp
// Brief    : 256-bit unsigned less-than; combinational so it can be pipelined
//            later without touching the controller interface.
// Revision : 1.0 - initial release
// ============================================================================
module hash_lt_cmp
    import nonce_search_pkg::*;
(
    input  logic [HASH_W-1:0] i_a,
    input  logic [HASH_W-1:0] i_b,
    output logic              o_lt
);

    assign o_lt = (i_a < i_b);

endmodule
`default_nettype wire

// File: rtl/nonce_search_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : nonce_search_ctrl
// Brief    : Sequences one SHA256 core through a nonce range, stopping on the
//            first hash below target, range end, abort or core timeout.
// Revision : 1.0 - initial release
// ============================================================================
module nonce_search_ctrl
    import nonce_search_pkg::*;
#(
    parameter int NONCE_WORD   = 3,
    parameter int CORE_TIMEOUT = 1024
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [BLOCK_W-1:0] cfg_block,
    input  logic [HASH_W-1:0]  cfg_target,
    input  logic [NONCE_W-1:0] cfg_nonce_start,
    input  logic [NONCE_W-1:0] cfg_nonce_end,
    input  logic               go,
    input  logic               abort,
    output logic               busy,
    output logic               found,
    output logic               exhausted,
    output logic               timeout,
    output logic [NONCE_W-1:0] result_nonce,
    output logic [HASH_W-1:0]  result_hash,
    output logic [31:0]        attempts,
    output logic               core_reset,
    output logic               core_start,
    output logic [BLOCK_W-1:0] core_block,
    input  logic [HASH_W-1:0]  core_hash,
    input  logic               core_done
);

    localparam logic [15:0] c_WAIT_LAST  = 16'(CORE_TIMEOUT - 1);
    localparam logic [3:0]  c_NONCE_WORD = 4'(NONCE_WORD);

    state_t              r_state;
    logic [BLOCK_W-1:0]  r_block;
    logic [HASH_W-1:0]   r_target;
    logic [NONCE_W-1:0]  r_nonce;
    logic [NONCE_W-1:0]  r_nonce_end;
    logic [15:0]         r_wait;
    logic                r_core_rst;
    logic                r_found;
    logic                r_exhausted;
    logic                r_timeout;
    logic [NONCE_W-1:0]  r_result_nonce;
    logic [HASH_W-1:0]   r_result_hash;
    logic [31:0]         r_attempts;
    logic [BLOCK_W-1:0]  r_core_block;
    logic                w_hit;

    hash_lt_cmp u_cmp (
        .i_a  (r_result_hash),
        .i_b  (r_target),
        .o_lt (w_hit)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state        <= S_IDLE;
            r_block        <= '0;
            r_target       <= '0;
            r_nonce        <= '0;
            r_nonce_end    <= '0;
            r_wait         <= '0;
            r_core_rst     <= 1'b0;
            r_found        <= 1'b0;
            r_exhausted    <= 1'b0;
            r_timeout      <= 1'b0;
            r_result_nonce <= '0;
            r_result_hash  <= '0;
            r_attempts     <= '0;
            r_core_block   <= '0;
        end else begin
            r_core_rst <= 1'b0;
            // Abort outranks done and timeout; status flags are left alone.
            if (abort && (r_state != S_IDLE)) begin
                r_core_rst <= 1'b1;
                r_state    <= S_IDLE;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (go && !abort) begin
                            r_block     <= cfg_block;
                            r_target    <= cfg_target;
                            r_nonce     <= cfg_nonce_start;
                            r_nonce_end <= cfg_nonce_end;
                            r_attempts  <= '0;
                            r_found     <= 1'b0;
                            r_exhausted <= 1'b0;
                            r_timeout   <= 1'b0;
                            r_core_rst  <= 1'b1;
                            r_state     <= S_CRST;
                        end
                    end
                    S_CRST: begin
                        r_core_block <= insert_nonce(r_block, r_nonce, c_NONCE_WORD);
                        r_state      <= S_START;
                    end
                    S_START: begin
                        r_wait  <= '0;
                        r_state <= S_WAIT;
                    end
                    S_WAIT: begin
                        if (core_done) begin
                            r_result_hash <= core_hash;
                            r_state       <= S_CHECK;
                        end else if (r_wait == c_WAIT_LAST) begin
                            r_timeout  <= 1'b1;
                            r_core_rst <= 1'b1;
                            r_state    <= S_IDLE;
                        end else begin
                            r_wait <= r_wait + 16'd1;
                        end
                    end
                    S_CHECK: begin
                        r_result_nonce <= r_nonce;
                        if (r_attempts != '1) begin
                            r_attempts <= r_attempts + 32'd1;
                        end
                        if (w_hit) begin
                            r_found <= 1'b1;
                            r_state <= S_IDLE;
                        end else if (r_nonce == r_nonce_end) begin
                            r_exhausted <= 1'b1;
                            r_state     <= S_IDLE;
                        end else begin
                            // Core is re-reset so a lingering done cannot leak into the next WAIT.
                            r_nonce    <= r_nonce + 32'd1;
                            r_core_rst <= 1'b1;
                            r_state    <= S_CRST;
                        end
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    assign busy         = (r_state != S_IDLE);
    assign found        = r_found;
    assign exhausted    = r_exhausted;
    assign timeout      = r_timeout;
    assign result_nonce = r_result_nonce;
    assign result_hash  = r_result_hash;
    assign attempts     = r_attempts;
    assign core_reset   = reset | r_core_rst;
    assign core_start   = (r_state == S_START);
    assign core_block   = r_core_block;

endmodule
`default_nettype wire

// File: tb/tb_nonce_search_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_nonce_search_ctrl
// Brief    : Self-checking bench for nonce_search_ctrl with a behavioural core.
// Revision : 1.0 - initial release
// ============================================================================
module tb_nonce_search_ctrl;

    localparam int NW = 3;
    localparam int TO = 16;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [511:0] cfg_block = '0;
    logic [255:0] cfg_target = '0;
    logic [31:0]  cfg_nonce_start = '0;
    logic [31:0]  cfg_nonce_end = '0;
    logic         go = 1'b0;
    logic         abort = 1'b0;
    logic         busy, found, exhausted, timeout;
    logic [31:0]  result_nonce;
    logic [255:0] result_hash;
    logic [31:0]  attempts;
    logic         core_reset, core_start;
    logic [511:0] core_block;
    logic [255:0] core_hash = '0;
    logic         core_done = 1'b0;

    int n_chk = 0;
    int n_err = 0;
    int cyc = 0;
    int start_cyc = 0;
    int core_d = 4;
    int hmode = 0;
    int cnt = -1;
    logic [511:0] exp_tmpl = '0;
    logic [511:0] m_blk;
    logic [31:0]  tried[$];
    logic [31:0]  exp_seq[$];
    logic         s_rst = 1'b1;
    logic         s_start = 1'b0;
    logic [511:0] s_blk = '0;

    always #5 clk = ~clk;

    nonce_search_ctrl #(.NONCE_WORD(NW), .CORE_TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset), .cfg_block(cfg_block), .cfg_target(cfg_target),
        .cfg_nonce_start(cfg_nonce_start), .cfg_nonce_end(cfg_nonce_end),
        .go(go), .abort(abort), .busy(busy), .found(found), .exhausted(exhausted),
        .timeout(timeout), .result_nonce(result_nonce), .result_hash(result_hash),
        .attempts(attempts), .core_reset(core_reset), .core_start(core_start),
        .core_block(core_block), .core_hash(core_hash), .core_done(core_done)
    );

    function automatic logic [255:0] hf(input logic [31:0] n, input int mode);
        if (mode == 0) return {224'd0, n};
        return {n * 32'h9E3779B1, {7{n ^ 32'h5BD1E995}}};
    endfunction

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Core model: sees start/reset at the posedge after they are driven, done D edges later.
    always @(negedge clk) begin
        s_rst   = core_reset;
        s_start = core_start;
        s_blk   = core_block;
        if (core_start === 1'b1) begin
            m_blk = core_block;
            m_blk[NW*32 +: 32] = exp_tmpl[NW*32 +: 32];
            check("core_block_template", {255'd0, m_blk === exp_tmpl}, 256'd1);
            tried.push_back(core_block[NW*32 +: 32]);
            start_cyc = cyc + 1;
        end
    end

    always @(posedge clk) begin
        cyc++;
        if (s_rst) begin
            core_done <= 1'b0;
            cnt = -1;
        end else if (s_start) begin
            core_hash <= hf(s_blk[NW*32 +: 32], hmode);
            if (core_d == 1) core_done <= 1'b1;
            else cnt = (core_d == 0) ? -1 : core_d - 1;
        end else if (cnt > 0) begin
            cnt--;
            if (cnt == 0) core_done <= 1'b1;
        end
    end

    // Reference: walk the range with plain arithmetic and stop on the rules.
    task automatic model(input logic [31:0] st, input logic [31:0] en, input logic [255:0] tg,
                         input int mode, output bit f, output bit ex,
                         output logic [31:0] rn, output int att);
        logic [31:0] n;
        n = st; f = 0; ex = 0; att = 0;
        exp_seq.delete();
        for (int k = 0; k < 64; k++) begin
            exp_seq.push_back(n);
            att++;
            if (hf(n, mode) < tg) begin f = 1; break; end
            if (n == en) begin ex = 1; break; end
            n = n + 32'd1;
        end
        rn = n;
    endtask

    task automatic run(input logic [31:0] st, input logic [31:0] en, input logic [255:0] tg,
                       input int d, input int mode, input bit disturb);
        bit f, ex;
        logic [31:0] rn;
        int att, n;
        for (int w = 0; w < 16; w++) exp_tmpl = {exp_tmpl[479:0], $urandom};
        core_d = d; hmode = mode;
        tried.delete();
        cfg_block = exp_tmpl; cfg_target = tg; cfg_nonce_start = st; cfg_nonce_end = en;
        go = 1'b1;
        @(negedge clk);
        go = 1'b0;
        n = 0;
        while (busy === 1'b1 && n < 2000) begin
            if (disturb && n == 3) begin
                go = 1'b1;
                cfg_block = ~exp_tmpl; cfg_target = '1;
                cfg_nonce_start = st + 32'd100; cfg_nonce_end = st + 32'd100;
            end else go = 1'b0;
            @(negedge clk);
            n++;
        end
        go = 1'b0;
        check("run_bound", {255'd0, n < 2000}, 256'd1);
        if (d == 0) begin
            check("to_flag", {255'd0, timeout}, 256'd1);
            check("to_found", {255'd0, found}, 256'd0);
            check("to_exhausted", {255'd0, exhausted}, 256'd0);
            check("to_attempts", {224'd0, attempts}, 256'd0);
            check("to_latency", 256'(cyc - start_cyc), 256'(TO));
            check("to_core_reset", {255'd0, core_reset}, 256'd1);
        end else begin
            model(st, en, tg, mode, f, ex, rn, att);
            check("found", {255'd0, found}, {255'd0, f});
            check("exhausted", {255'd0, exhausted}, {255'd0, ex});
            check("timeout", {255'd0, timeout}, 256'd0);
            check("result_nonce", {224'd0, result_nonce}, {224'd0, rn});
            check("result_hash", result_hash, hf(rn, mode));
            check("attempts", {224'd0, attempts}, 256'(att));
            check("latency", 256'(n), 256'(att * (d + 3)));
            check("tried_count", 256'(tried.size()), 256'(exp_seq.size()));
            for (int i = 0; i < exp_seq.size() && i < tried.size(); i++)
                check("tried_nonce", {224'd0, tried[i]}, {224'd0, exp_seq[i]});
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int seen, n;
        bit prev;
        repeat (3) @(negedge clk);
        check("rst_core_reset", {255'd0, core_reset}, 256'd1);
        check("rst_busy", {255'd0, busy}, 256'd0);
        check("rst_flags", {253'd0, found, exhausted, timeout}, 256'd0);
        check("rst_core_start", {255'd0, core_start}, 256'd0);
        check("rst_core_block", core_block[255:0] | core_block[511:256], 256'd0);
        check("rst_results", result_hash | {224'd0, result_nonce} | {224'd0, attempts}, 256'd0);
        reset = 1'b0;
        @(negedge clk);
        check("idle_core_reset", {255'd0, core_reset}, 256'd0);

        run(32'd2, 32'd9, 256'd5, 4, 0, 1'b0);

        go = 1'b1; abort = 1'b1;
        @(negedge clk);
        go = 1'b0; abort = 1'b0;
        check("go_abort_busy", {255'd0, busy}, 256'd0);
        check("go_abort_found_kept", {255'd0, found}, 256'd1);

        run(32'hFFFFFFFE, 32'd1, 256'd0, 4, 0, 1'b0);
        run(32'd7, 32'd7, 256'd7, 4, 0, 1'b0);
        run(32'd50, 32'd55, 256'd0, 3, 0, 1'b1);

        for (int t = 0; t < 8; t++) begin
            logic [31:0] st;
            int len;
            st = ($urandom_range(0, 1) == 1) ? 32'hFFFFFFFF - 32'($urandom_range(0, 4)) : $urandom;
            len = int'($urandom_range(0, 6));
            run(st, st + 32'(len), {32'($urandom_range(0, 32'h3FFFFFFF)), 224'($urandom)},
                int'($urandom_range(2, 10)), 1, 1'b0);
        end

        run(32'd0, 32'd5, 256'd0, 0, 0, 1'b0);

        // Abort on the same cycle the second attempt's done arrives.
        core_d = 5; hmode = 0; tried.delete();
        cfg_block = exp_tmpl; cfg_target = '0; cfg_nonce_start = 32'd100; cfg_nonce_end = 32'd104;
        go = 1'b1;
        @(negedge clk);
        go = 1'b0;
        seen = 0; n = 0; prev = 1'b0;
        while (n < 500 && seen < 2) begin
            if (core_done && !prev && busy) seen++;
            prev = core_done;
            if (seen < 2) begin
                @(negedge clk);
                n++;
            end
        end
        check("abort_reached", 256'(seen), 256'd2);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_busy", {255'd0, busy}, 256'd0);
        check("abort_flags", {253'd0, found, exhausted, timeout}, 256'd0);
        check("abort_attempts", {224'd0, attempts}, 256'd1);
        check("abort_result_hash", result_hash, hf(32'd100, 0));
        check("abort_core_reset", {255'd0, core_reset}, 256'd1);

        // Reset while the core is stuck in WAIT.
        core_d = 0;
        cfg_nonce_start = 32'd1; cfg_nonce_end = 32'd3;
        go = 1'b1;
        @(negedge clk);
        go = 1'b0;
        repeat (4) @(negedge clk);
        check("pre_reset_busy", {255'd0, busy}, 256'd1);
        reset = 1'b1;
        @(negedge clk);
        check("mid_rst_busy", {255'd0, busy}, 256'd0);
        check("mid_rst_flags", {253'd0, found, exhausted, timeout}, 256'd0);
        check("mid_rst_results", result_hash | {224'd0, result_nonce} | {224'd0, attempts}, 256'd0);
        check("mid_rst_core_block", core_block[255:0] | core_block[511:256], 256'd0);
        check("mid_rst_core_start", {255'd0, core_start}, 256'd0);
        check("mid_rst_core_reset", {255'd0, core_reset}, 256'd1);
        reset = 1'b0;
        @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
`default_nettype wire
